// File: rtl/mmu_pkg.sv
// Shared MMU definitions: PTW <-> dmem request/response structs, command and type codes,
// and the dmem responder's state encoding.
package mmu_pkg;

  localparam logic [4:0] M_XRD = 5'b00000;
  localparam logic [3:0] MT_D  = 4'b0011;

  typedef struct packed {
    logic        valid;
    logic        phys;
    logic [4:0]  cmd;
    logic [3:0]  typ;
    logic [63:0] addr;
    logic        kill;
    logic [63:0] data;
  } ptw_dmem_req_t;

  typedef struct packed {
    ptw_dmem_req_t req;
  } ptw_dmem_comm_t;

  typedef struct packed {
    logic        valid;
    logic        nack;
    logic [63:0] data;
  } dmem_ptw_resp_t;

  typedef struct packed {
    logic           dmem_ready;
    dmem_ptw_resp_t resp;
  } dmem_ptw_comm_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // A PTE read is serviceable only as a physical, aligned, 64-bit load.
  function automatic logic pte_req_bad(logic [4:0] cmd, logic [3:0] typ, logic phys,
                                       logic [2:0] addr_lo);
    return (cmd != M_XRD) || (typ != MT_D) || !phys || (addr_lo != 3'b000);
  endfunction

endpackage

// File: rtl/ptw_dmem_ram.sv
// Page-table backing store: one synchronous read port, one synchronous backdoor write port.
// A same-edge collision returns the old contents (read-before-write), which maps onto BRAM.
module ptw_dmem_ram #(
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned IdxW = $clog2(MEM_WORDS)
) (
  input  logic            clk_i,
  input  logic            rd_en,
  input  logic [IdxW-1:0] rd_idx,
  output logic [63:0]     rd_data,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  logic [63:0]     wr_data
);

  logic [63:0] mem [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ptw_dmem_responder.sv
// Memory-side responder for the PTW dmem port: single outstanding PTE read with
// configurable latency, protocol/range checks, nack injection and request statistics.
module ptw_dmem_responder
  import mmu_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned NACK_EVERY = 0,
  localparam int unsigned IdxW = $clog2(MEM_WORDS)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  ptw_dmem_comm_t  ptw_dmem_comm_i,
  output dmem_ptw_comm_t  dmem_ptw_comm_o,
  input  logic            bd_we_i,
  input  logic [IdxW-1:0] bd_idx_i,
  input  logic [63:0]     bd_data_i,
  output logic [31:0]     req_cnt_o,
  output logic [31:0]     nack_cnt_o
);

  localparam logic [3:0] LatInit = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] inj_q, inj_d;
  logic [31:0] req_cnt_q, nack_cnt_q;

  logic [63:0] addr_q;
  logic [4:0]  cmd_q;
  logic [3:0]  typ_q;
  logic        phys_q;
  logic        fire_q;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_nack_q, resp_nack_d;
  logic        resp_zero_q, resp_zero_d;

  logic        accept;
  logic        fire_now;
  logic        enter_resp;
  logic        bad;
  logic        in_range;
  logic [63:0] src_addr;
  logic [63:0] src_off;
  logic [4:0]  src_cmd;
  logic [3:0]  src_typ;
  logic        src_phys;
  logic        src_fire;
  logic [63:0] rd_data;
  logic        unused_bits;

  assign accept   = ptw_dmem_comm_i.req.valid && (state_q == S_IDLE);
  assign fire_now = (NACK_EVERY != 0) && (inj_q == 32'(NACK_EVERY - 1));

  // In S_IDLE the live request is checked (needed for LATENCY==1), otherwise the latched one.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_addr = ptw_dmem_comm_i.req.addr;
      src_cmd  = ptw_dmem_comm_i.req.cmd;
      src_typ  = ptw_dmem_comm_i.req.typ;
      src_phys = ptw_dmem_comm_i.req.phys;
      src_fire = fire_now;
    end else begin
      src_addr = addr_q;
      src_cmd  = cmd_q;
      src_typ  = typ_q;
      src_phys = phys_q;
      src_fire = fire_q;
    end
  end

  // Addresses below the base wrap to a huge offset, so one upper-bits test covers both ends.
  assign src_off  = src_addr - BASE_ADDR;
  assign in_range = (src_off[63:IdxW+3] == '0);
  assign bad      = pte_req_bad(src_cmd, src_typ, src_phys, src_addr[2:0]) || src_fire;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    resp_valid_d = 1'b0;
    resp_nack_d  = 1'b0;
    resp_zero_d  = resp_zero_q;
    enter_resp   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_d = LatInit;
          if (LATENCY == 1) enter_resp = 1'b1;
          else              state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ptw_dmem_comm_i.req.kill) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
          if (lat_q == 4'd1) enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      state_d      = S_RESP;
      resp_nack_d  = bad;
      resp_valid_d = !bad;
      resp_zero_d  = !in_range;
    end
  end

  always_comb begin
    inj_d = inj_q;
    if (accept && (NACK_EVERY != 0)) inj_d = fire_now ? 32'd0 : inj_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      lat_q        <= 4'd0;
      inj_q        <= 32'd0;
      req_cnt_q    <= 32'd0;
      nack_cnt_q   <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_nack_q  <= 1'b0;
      resp_zero_q  <= 1'b0;
      addr_q       <= 64'd0;
      cmd_q        <= 5'd0;
      typ_q        <= 4'd0;
      phys_q       <= 1'b0;
      fire_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      inj_q        <= inj_d;
      resp_valid_q <= resp_valid_d;
      resp_nack_q  <= resp_nack_d;
      resp_zero_q  <= resp_zero_d;
      if (accept && (req_cnt_q != '1)) req_cnt_q <= req_cnt_q + 32'd1;
      if (resp_nack_d && (nack_cnt_q != '1)) nack_cnt_q <= nack_cnt_q + 32'd1;
      if (accept) begin
        addr_q <= ptw_dmem_comm_i.req.addr;
        cmd_q  <= ptw_dmem_comm_i.req.cmd;
        typ_q  <= ptw_dmem_comm_i.req.typ;
        phys_q <= ptw_dmem_comm_i.req.phys;
        fire_q <= fire_now;
      end
    end
  end

  ptw_dmem_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk_i  (clk_i),
    .rd_en  (accept),
    .rd_idx (src_off[IdxW+2:3]),
    .rd_data(rd_data),
    .wr_en  (bd_we_i),
    .wr_idx (bd_idx_i),
    .wr_data(bd_data_i)
  );

  // The RAM output register holds the sampled entry; gating keeps data 0 outside a valid beat.
  assign dmem_ptw_comm_o.dmem_ready = (state_q == S_IDLE);
  assign dmem_ptw_comm_o.resp.valid = resp_valid_q;
  assign dmem_ptw_comm_o.resp.nack  = resp_nack_q;
  assign dmem_ptw_comm_o.resp.data  = (resp_valid_q && !resp_zero_q) ? rd_data : 64'd0;

  assign req_cnt_o  = req_cnt_q;
  assign nack_cnt_o = nack_cnt_q;

  assign unused_bits = ^{ptw_dmem_comm_i.req.data, src_off[2:0]};

endmodule

// File: tb/tb_ptw_dmem_responder.sv
// Bench for ptw_dmem_responder: two instances (plain, and longer latency with nack injection)
// checked against a rule-level model of the store, checks, injection and counters.
module tb_ptw_dmem_responder;
  import mmu_pkg::*;

  localparam int unsigned W    = 64;
  localparam int unsigned IW   = 6;
  localparam logic [63:0] BASE = 64'h8000_0000;

  int unsigned lat_of [2] = '{2, 4};
  int unsigned ne_of  [2] = '{0, 3};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  ptw_dmem_comm_t req_s [2];
  dmem_ptw_comm_t rsp_s [2];
  logic           bd_we [2];
  logic [IW-1:0]  bd_idx [2];
  logic [63:0]    bd_data [2];
  logic [31:0]    req_cnt [2];
  logic [31:0]    nack_cnt [2];

  logic [63:0] mem_m [2][W];
  int unsigned acc_m [2];
  int unsigned nack_m [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ptw_dmem_responder #(
    .MEM_WORDS(W), .BASE_ADDR(BASE), .LATENCY(2), .NACK_EVERY(0)
  ) dut0 (
    .clk_i(clk), .rstn_i(rstn), .ptw_dmem_comm_i(req_s[0]), .dmem_ptw_comm_o(rsp_s[0]),
    .bd_we_i(bd_we[0]), .bd_idx_i(bd_idx[0]), .bd_data_i(bd_data[0]),
    .req_cnt_o(req_cnt[0]), .nack_cnt_o(nack_cnt[0])
  );

  ptw_dmem_responder #(
    .MEM_WORDS(W), .BASE_ADDR(BASE), .LATENCY(4), .NACK_EVERY(3)
  ) dut1 (
    .clk_i(clk), .rstn_i(rstn), .ptw_dmem_comm_i(req_s[1]), .dmem_ptw_comm_o(rsp_s[1]),
    .bd_we_i(bd_we[1]), .bd_idx_i(bd_idx[1]), .bd_data_i(bd_data[1]),
    .req_cnt_o(req_cnt[1]), .nack_cnt_o(nack_cnt[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected outcome of the next accepted read, straight from the response rules.
  function automatic void expect_resp(input int k, input logic [63:0] addr,
                                      input logic [4:0] cmd, input logic [3:0] typ,
                                      input logic phys, output logic ev, output logic en,
                                      output logic [63:0] ed);
    logic fire;
    acc_m[k]++;
    fire = (ne_of[k] != 0) && (acc_m[k] % ne_of[k] == 0);
    en = (cmd != 5'b00000) || (typ != 4'b0011) || !phys || (addr[2:0] != 3'b000) || fire;
    ev = !en;
    ed = 64'd0;
    if (ev && addr >= BASE && addr < BASE + 64'(8 * W)) ed = mem_m[k][int'((addr - BASE) >> 3)];
    if (en) nack_m[k]++;
  endfunction

  task automatic bd_write(input int k, input int idx, input logic [63:0] d);
    @(negedge clk);
    bd_we[k] = 1'b1; bd_idx[k] = IW'(idx); bd_data[k] = d;
    @(posedge clk); #1;
    bd_we[k] = 1'b0;
    mem_m[k][idx] = d;
  endtask

  task automatic do_req(input int k, input logic [63:0] addr, input logic [4:0] cmd,
                        input logic [3:0] typ, input logic phys, input logic bd_en,
                        input int bdi, input logic [63:0] bdd, input string name,
                        output logic [63:0] got, output logic gv, output logic gn);
    logic ev, en;
    logic [63:0] ed;
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_s[k].dmem_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, 64'(rsp_s[k].dmem_ready), 64'd1);
    expect_resp(k, addr, cmd, typ, phys, ev, en, ed);
    req_s[k].req.valid = 1'b1; req_s[k].req.addr = addr; req_s[k].req.cmd = cmd;
    req_s[k].req.typ = typ; req_s[k].req.phys = phys; req_s[k].req.kill = 1'b0;
    req_s[k].req.data = {$urandom, $urandom};
    if (bd_en) begin
      bd_we[k] = 1'b1; bd_idx[k] = IW'(bdi); bd_data[k] = bdd;
    end
    @(posedge clk); #1;
    req_s[k].req.valid = 1'b0;
    bd_we[k] = 1'b0;
    if (bd_en) mem_m[k][bdi] = bdd;
    for (int c = 1; c < int'(lat_of[k]); c++) begin
      @(negedge clk);
      chk({name, " busy rdy/v/n"},
          64'({rsp_s[k].dmem_ready, rsp_s[k].resp.valid, rsp_s[k].resp.nack}), 64'd0);
    end
    @(negedge clk);
    gv = rsp_s[k].resp.valid; gn = rsp_s[k].resp.nack; got = rsp_s[k].resp.data;
    chk({name, " valid"}, 64'(gv), 64'(ev));
    chk({name, " nack"}, 64'(gn), 64'(en));
    chk({name, " data"}, got, ed);
    chk({name, " ready in resp"}, 64'(rsp_s[k].dmem_ready), 64'd0);
    @(negedge clk);
    chk({name, " after rdy/v/n/z"}, 64'({rsp_s[k].dmem_ready, rsp_s[k].resp.valid,
        rsp_s[k].resp.nack, rsp_s[k].resp.data == 64'd0}), 64'b1001);
    chk({name, " req_cnt"}, 64'(req_cnt[k]), 64'(acc_m[k]));
    chk({name, " nack_cnt"}, 64'(nack_cnt[k]), 64'(nack_m[k]));
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [4:0]  cmd;
    logic [3:0]  typ;
    logic        phys;
    logic        ev;
    logic        en;
    logic [63:0] ed;
  } vec_t;

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [10];
    logic [63:0] got, pte, ppn, a;
    logic gv, gn;
    int lvl;
    int vpn [3];

    tbl[0] = '{BASE,                 5'd0, 4'd3, 1'b1, 1'b1, 1'b0, pat(0)};
    tbl[1] = '{BASE + 64'(8 * 63),   5'd0, 4'd3, 1'b1, 1'b1, 1'b0, pat(63)};
    tbl[2] = '{BASE + 64'(8 * 64),   5'd0, 4'd3, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[3] = '{BASE - 64'd8,         5'd0, 4'd3, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[4] = '{BASE + 64'h10,        5'd1, 4'd3, 1'b1, 1'b0, 1'b1, 64'd0};
    tbl[5] = '{BASE + 64'h10,        5'd0, 4'd2, 1'b1, 1'b0, 1'b1, 64'd0};
    tbl[6] = '{BASE + 64'h10,        5'd0, 4'd3, 1'b0, 1'b0, 1'b1, 64'd0};
    tbl[7] = '{BASE + 64'h11,        5'd0, 4'd3, 1'b1, 1'b0, 1'b1, 64'd0};
    tbl[8] = '{BASE + 64'(8*64) + 2, 5'd0, 4'd3, 1'b1, 1'b0, 1'b1, 64'd0};
    tbl[9] = '{BASE + 64'h30,        5'd0, 4'd3, 1'b1, 1'b1, 1'b0, pat(6)};

    for (int k = 0; k < 2; k++) begin
      req_s[k] = '0; bd_we[k] = 1'b0; bd_idx[k] = '0; bd_data[k] = '0;
      acc_m[k] = 0; nack_m[k] = 0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset ready", 64'(rsp_s[k].dmem_ready), 64'd1);
      chk("reset v/n", 64'({rsp_s[k].resp.valid, rsp_s[k].resp.nack}), 64'd0);
      chk("reset data", rsp_s[k].resp.data, 64'd0);
      chk("reset counters", {req_cnt[k], nack_cnt[k]}, 64'd0);
    end
    #20;
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < int'(W); i++) begin
      bd_write(0, i, pat(i));
      bd_write(1, i, pat(i));
    end

    // Single read, then out-of-range and misaligned.
    bd_write(0, 5, 64'h0000_0000_2000_0401);
    do_req(0, 64'h8000_0028, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, "single", got, gv, gn);
    chk("single data const", got, 64'h0000_0000_2000_0401);
    do_req(0, 64'h7FFF_FFF8, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, "below base", got, gv, gn);
    chk("below base v/data", {63'd0, gv} | (got << 1), 64'd1);
    do_req(0, 64'h8000_0004, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, "misaligned", got, gv, gn);
    chk("misaligned nack_cnt", 64'(nack_cnt[0]), 64'd1);

    for (int i = 0; i < 10; i++) begin
      do_req(0, tbl[i].addr, tbl[i].cmd, tbl[i].typ, tbl[i].phys, 1'b0, 0, 64'd0,
             $sformatf("tbl%0d", i), got, gv, gn);
      chk($sformatf("tbl%0d v/n", i), 64'({gv, gn}), 64'({tbl[i].ev, tbl[i].en}));
      chk($sformatf("tbl%0d data", i), got, tbl[i].ed);
    end

    // Injection every third accept.
    for (int i = 0; i < 6; i++) begin
      do_req(1, BASE + 64'(8 * i), M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0,
             $sformatf("inj%0d", i), got, gv, gn);
      chk($sformatf("inj%0d nack", i), 64'(gn), 64'((i == 2) || (i == 5)));
    end
    chk("inj req_cnt", 64'(req_cnt[1]), 64'd6);
    chk("inj nack_cnt", 64'(nack_cnt[1]), 64'd2);

    // Kill in the cycle after accept.
    @(negedge clk);
    req_s[1].req.valid = 1'b1; req_s[1].req.addr = BASE + 64'h38;
    req_s[1].req.cmd = M_XRD; req_s[1].req.typ = MT_D; req_s[1].req.phys = 1'b1;
    @(posedge clk); #1;
    req_s[1].req.valid = 1'b0;
    acc_m[1]++;
    @(negedge clk);
    req_s[1].req.kill = 1'b1;
    @(posedge clk); #1;
    req_s[1].req.kill = 1'b0;
    @(negedge clk);
    chk("kill ready next", 64'(rsp_s[1].dmem_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      chk("kill no v/n", 64'({rsp_s[1].resp.valid, rsp_s[1].resp.nack}), 64'd0);
      @(negedge clk);
    end
    chk("kill req_cnt", 64'(req_cnt[1]), 64'd7);
    do_req(1, BASE + 64'h40, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, "post kill", got, gv, gn);
    chk("post kill data", got, pat(8));

    // Backdoor collision returns the old entry.
    bd_write(0, 3, 64'h55);
    do_req(0, BASE + 64'h18, M_XRD, MT_D, 1'b1, 1'b1, 3, 64'hAA, "collide", got, gv, gn);
    chk("collide old", got, 64'h55);
    do_req(0, BASE + 64'h18, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, "collide next", got, gv, gn);
    chk("collide new", got, 64'hAA);

    for (int r = 0; r < 60; r++) begin
      int k, off;
      logic [4:0] cmd;
      logic [3:0] typ;
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bd_write(k, int'($urandom_range(0, W - 1)), {$urandom, $urandom});
      off = int'($urandom_range(0, W + 8)) - 4;
      a = BASE + 64'(longint'(off) * 8);
      if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 7));
      cmd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : M_XRD;
      typ = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : MT_D;
      do_req(k, a, cmd, typ, ($urandom_range(0, 15) != 0), 1'b0, 0, 64'd0,
             $sformatf("rnd%0d", r), got, gv, gn);
    end

    // Walk a 3-level table to a 4 KiB leaf, all levels living in the base page.
    bd_write(0, 1, (64'h80000 << 10) | 64'h1);
    bd_write(0, 2, (64'h80000 << 10) | 64'h1);
    bd_write(0, 3, (64'h12345 << 10) | 64'hCF);
    vpn = '{3, 2, 1};
    ppn = 64'h80000;
    pte = 64'd0;
    lvl = 2;
    while (lvl >= 0) begin
      a = (ppn << 12) + 64'(8 * vpn[lvl]);
      do_req(0, a, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, $sformatf("walk l%0d", lvl), pte, gv, gn);
      ppn = {10'd0, pte[63:10]};
      if (pte[1] || pte[3] || !gv) break;
      lvl--;
    end
    chk("walk leaf level", 64'(lvl), 64'd0);
    chk("walk ppn", ppn, 64'h12345);

    // Reset while the response is on the bus.
    @(negedge clk);
    req_s[0].req.valid = 1'b1; req_s[0].req.addr = BASE + 64'h30;
    req_s[0].req.cmd = M_XRD; req_s[0].req.typ = MT_D; req_s[0].req.phys = 1'b1;
    @(posedge clk); #1;
    req_s[0].req.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset valid", 64'(rsp_s[0].resp.valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid reset ready", 64'(rsp_s[0].dmem_ready), 64'd1);
    chk("mid reset v/n", 64'({rsp_s[0].resp.valid, rsp_s[0].resp.nack}), 64'd0);
    chk("mid reset data", rsp_s[0].resp.data, 64'd0);
    chk("mid reset counters", {req_cnt[0], nack_cnt[0]}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    acc_m = '{0, 0};
    nack_m = '{0, 0};
    do_req(0, BASE + 64'h30, M_XRD, MT_D, 1'b1, 1'b0, 0, 64'd0, "post reset", got, gv, gn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
